// File: rtl/rom_load_arbiter.sv
// rom_load_arbiter
//   Shares the single port of the game core's ROM/palette block RAMs between
//   the HPS download stream and CPU reads. The CPU always has priority. A
//   one-entry buffer decouples the download strobe from the port. Download
//   addresses are decoded into per-region write strobes and region-relative
//   offsets. The block holds the core in reset from power-up until a download
//   has finished and a settle interval has passed. It asserts that reset again
//   for any later download.
//
// Ports
//   CLK, RESET    : system clock, asynchronous active-high reset
//   dn_download   : download-active level from the HPS
//   dn_wr         : one-cycle byte-write strobe
//   dn_addr       : download byte address
//   dn_data       : download byte
//   dn_wait       : buffer full; the source must not strobe
//   cpu_rd        : CPU claims the memory port this cycle
//   cpu_addr      : CPU read address
//   mem_addr      : shared port address (region offset on grant, else cpu_addr)
//   mem_din       : shared port write data
//   mem_we        : one-hot write enables {palette, graphics, program}
//   mem_sel       : 1 = loader owns the port this cycle
//   core_reset    : reset to the game core
//   dl_done       : one-cycle pulse when core_reset is released
//   byte_count    : committed in-range writes since the last download start
//   overflow      : sticky; a strobe was dropped because the buffer was busy

module rom_load_arbiter #(
  parameter logic [15:0] PGM_END     = 16'h4000,
  parameter logic [15:0] GFX_END     = 16'h5000,
  parameter logic [15:0] PAL_END     = 16'h5020,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic        dn_wait,
  input  logic        cpu_rd,
  input  logic [15:0] cpu_addr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic [2:0]  mem_we,
  output logic        mem_sel,
  output logic        core_reset,
  output logic        dl_done,
  output logic [16:0] byte_count,
  output logic        overflow
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_LOAD,
    S_DRAIN,
    S_HOLD,
    S_RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] hold_cnt;

  // Registered copy of dn_download, used for edge detection
  logic dl_q;
  logic dl_rise;
  logic dl_fall;

  // One-entry write buffer
  logic        valid;
  logic [15:0] buf_addr;
  logic [7:0]  buf_data;

  logic        grant;
  logic        load;
  logic        drop;
  logic        commit;
  logic [2:0]  region;
  logic [15:0] base;

  assign dl_rise = dn_download & ~dl_q;
  assign dl_fall = ~dn_download & dl_q;

  assign grant = valid & ~cpu_rd;
  // A strobe is accepted into an empty buffer, or into a full buffer whose
  // entry leaves on the same edge. Otherwise the strobe is lost.
  assign load  = dn_wr & (~valid | grant);
  assign drop  = dn_wr & valid & ~grant;

  // Region decode of the buffered address. An out-of-range address leaves
  // region at zero, so its grant consumes the entry without a write.
  // NOTE: every variable in always_comb gets a default first. A path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    region = 3'b000;
    base   = PAL_END;
    if (buf_addr < PGM_END) begin
      region = 3'b001;
      base   = 16'h0000;
    end else if (buf_addr < GFX_END) begin
      region = 3'b010;
      base   = PGM_END;
    end else if (buf_addr < PAL_END) begin
      region = 3'b100;
      base   = GFX_END;
    end
  end

  assign commit   = grant & (|region);
  assign mem_sel  = grant;
  assign mem_we   = grant ? region : 3'b000;
  assign mem_addr = grant ? (buf_addr - base) : cpu_addr;
  assign mem_din  = buf_data;
  assign dn_wait  = valid & ~grant;

  // NOTE: sequential state uses non-blocking assignments only. Each register
  // then sees the pre-edge value of every other register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dl_q <= 1'b0;
    end else begin
      dl_q <= dn_download;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid    <= 1'b0;
      buf_addr <= 16'h0000;
      buf_data <= 8'h00;
    end else if (load) begin
      valid    <= 1'b1;
      buf_addr <= dn_addr;
      buf_data <= dn_data;
    end else if (grant) begin
      valid    <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Every rise of dn_download enters LOAD, so the rise also clears the count.
  // The clear wins over a commit on the same edge, because that byte belongs
  // to the previous download.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      byte_count <= 17'h00000;
    end else if (dl_rise) begin
      byte_count <= 17'h00000;
    end else if (commit && (byte_count != 17'h1FFFF)) begin
      byte_count <= byte_count + 17'h00001;
    end
  end

  // Load/release sequencer. core_reset and dl_done are registered here, so
  // the release and the pulse leave on the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_EMPTY;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
      dl_done    <= 1'b0;
    end else begin
      dl_done <= 1'b0;
      case (state)
        S_EMPTY: begin
          if (dl_rise) state <= S_LOAD;
        end
        S_LOAD: begin
          if (dl_fall) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (dl_rise) begin
            state <= S_LOAD;
          end else if (!valid) begin
            state    <= S_HOLD;
            hold_cnt <= CW'(HOLD_CYCLES - 1);
          end
        end
        S_HOLD: begin
          if (dl_rise) begin
            state <= S_LOAD;
          end else if (hold_cnt == '0) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
            dl_done    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - CW'(1);
          end
        end
        S_RUN: begin
          if (dl_rise) begin
            state      <= S_LOAD;
            core_reset <= 1'b1;
          end
        end
        default: begin
          state      <= S_EMPTY;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// tb_rom_load_arbiter
//   Directed bench for rom_load_arbiter with HOLD_CYCLES = 4. Inputs change
//   1 time unit after the rising edge. Outputs are sampled inside the same
//   cycle, before the next edge.

module tb_rom_load_arbiter;

  logic        CLK;
  logic        RESET;
  logic        dn_download;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wait;
  logic        cpu_rd;
  logic [15:0] cpu_addr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic [2:0]  mem_we;
  logic        mem_sel;
  logic        core_reset;
  logic        dl_done;
  logic [16:0] byte_count;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  rom_load_arbiter #(
    .PGM_END    (16'h4000),
    .GFX_END    (16'h5000),
    .PAL_END    (16'h5020),
    .HOLD_CYCLES(4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .dn_download(dn_download),
    .dn_wr      (dn_wr),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .dn_wait    (dn_wait),
    .cpu_rd     (cpu_rd),
    .cpu_addr   (cpu_addr),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_sel    (mem_sel),
    .core_reset (core_reset),
    .dl_done    (dl_done),
    .byte_count (byte_count),
    .overflow   (overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, " core_reset"}, 32'(core_reset), 32'd1);
    check({tag, " dn_wait"},    32'(dn_wait),    32'd0);
    check({tag, " mem_we"},     32'(mem_we),     32'd0);
    check({tag, " mem_sel"},    32'(mem_sel),    32'd0);
    check({tag, " dl_done"},    32'(dl_done),    32'd0);
    check({tag, " byte_count"}, 32'(byte_count), 32'd0);
    check({tag, " overflow"},   32'(overflow),   32'd0);
    check({tag, " mem_addr"},   32'(mem_addr),   32'(cpu_addr));
  endtask

  int done_at;

  initial begin
    RESET       = 1'b1;
    dn_download = 1'b0;
    dn_wr       = 1'b0;
    dn_addr     = 16'h0000;
    dn_data     = 8'h00;
    cpu_rd      = 1'b0;
    cpu_addr    = 16'h1234;
    #1;
    check_idle_reset("por");
    tick();
    tick();
    @(negedge CLK);
    RESET = 1'b0;

    // ---- Download with idle CPU ----
    tick();
    dn_download = 1'b1;
    tick();
    dn_wr = 1'b1; dn_addr = 16'h0000; dn_data = 8'hAA;
    tick();
    dn_wr = 1'b1; dn_addr = 16'h4000; dn_data = 8'h55;
    #1;
    check("pgm we",   32'(mem_we),   32'h1);
    check("pgm addr", 32'(mem_addr), 32'h0000);
    check("pgm din",  32'(mem_din),  32'hAA);
    check("pgm sel",  32'(mem_sel),  32'd1);
    check("pgm wait", 32'(dn_wait),  32'd0);
    tick();
    dn_wr = 1'b1; dn_addr = 16'h5001; dn_data = 8'h12;
    #1;
    check("gfx we",   32'(mem_we),   32'h2);
    check("gfx addr", 32'(mem_addr), 32'h0000);
    check("gfx din",  32'(mem_din),  32'h55);
    check("gfx wait", 32'(dn_wait),  32'd0);
    tick();
    dn_wr = 1'b1; dn_addr = 16'h6000; dn_data = 8'h99;
    #1;
    check("pal we",   32'(mem_we),   32'h4);
    check("pal addr", 32'(mem_addr), 32'h0001);
    check("pal din",  32'(mem_din),  32'h12);
    tick();
    dn_wr = 1'b0;
    #1;
    check("oor we",   32'(mem_we),   32'h0);
    check("oor sel",  32'(mem_sel),  32'd1);
    tick();
    check("dl1 sel idle",   32'(mem_sel),    32'd0);
    check("dl1 byte_count", 32'(byte_count), 32'd3);
    check("dl1 core_reset", 32'(core_reset), 32'd1);

    // ---- CPU contention ----
    cpu_rd = 1'b1; cpu_addr = 16'hBEEF;
    dn_wr = 1'b1; dn_addr = 16'h0010; dn_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      dn_wr = 1'b0;
      #1;
      check("cont we",   32'(mem_we),   32'h0);
      check("cont addr", 32'(mem_addr), 32'hBEEF);
      check("cont wait", 32'(dn_wait),  32'd1);
    end
    tick();
    cpu_rd = 1'b0;
    #1;
    check("cont commit we",   32'(mem_we),   32'h1);
    check("cont commit addr", 32'(mem_addr), 32'h0010);
    check("cont commit din",  32'(mem_din),  32'h77);
    check("cont commit wait", 32'(dn_wait),  32'd0);
    tick();
    check("cont byte_count", 32'(byte_count), 32'd4);
    check("cont we after",   32'(mem_we),     32'h0);

    // ---- Overflow ----
    cpu_rd = 1'b1;
    dn_wr = 1'b1; dn_addr = 16'h4002; dn_data = 8'h11;
    tick();
    dn_wr = 1'b1; dn_addr = 16'h4003; dn_data = 8'h22;
    #1;
    check("ovf not yet", 32'(overflow), 32'd0);
    tick();
    dn_wr = 1'b0;
    #1;
    check("ovf set",  32'(overflow), 32'd1);
    check("ovf wait", 32'(dn_wait),  32'd1);
    tick();
    cpu_rd = 1'b0;
    #1;
    check("ovf first we",   32'(mem_we),   32'h2);
    check("ovf first addr", 32'(mem_addr), 32'h0002);
    check("ovf first din",  32'(mem_din),  32'h11);
    tick();
    check("ovf no second", 32'(mem_sel),    32'd0);
    check("ovf sticky",    32'(overflow),   32'd1);
    check("ovf count",     32'(byte_count), 32'd5);

    // ---- Release with HOLD_CYCLES = 4 ----
    dn_download = 1'b0;
    tick();
    check("drain core_reset", 32'(core_reset), 32'd1);
    tick();
    check("hold entry core_reset", 32'(core_reset), 32'd1);
    check("hold entry dl_done",    32'(dl_done),    32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold core_reset", 32'(core_reset), 32'd1);
      check("hold dl_done",    32'(dl_done),    32'd0);
    end
    tick();
    check("release core_reset", 32'(core_reset), 32'd0);
    check("release dl_done",    32'(dl_done),    32'd1);
    tick();
    check("run dl_done",    32'(dl_done),    32'd0);
    check("run core_reset", 32'(core_reset), 32'd0);
    check("run byte_count", 32'(byte_count), 32'd5);

    // Writes are still accepted in RUN; last palette address
    dn_wr = 1'b1; dn_addr = 16'h501F; dn_data = 8'h3C;
    tick();
    dn_wr = 1'b0;
    #1;
    check("run we",   32'(mem_we),   32'h4);
    check("run addr", 32'(mem_addr), 32'h001F);
    tick();
    check("run count", 32'(byte_count), 32'd6);

    // ---- Reload from RUN ----
    dn_download = 1'b1;
    tick();
    check("reload core_reset", 32'(core_reset), 32'd1);
    check("reload byte_count", 32'(byte_count), 32'd0);
    check("reload dl_done",    32'(dl_done),    32'd0);

    // ---- Async reset mid-LOAD with a pending write ----
    cpu_rd = 1'b1; cpu_addr = 16'h0ABC;
    dn_wr = 1'b1; dn_addr = 16'h0005; dn_data = 8'hEE;
    tick();
    dn_wr = 1'b0;
    #1;
    check("pre-reset wait", 32'(dn_wait), 32'd1);
    #1;
    RESET = 1'b1;
    #1;
    check_idle_reset("async");
    @(negedge CLK);
    dn_download = 1'b0;
    cpu_rd = 1'b0;
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post-reset no write", 32'(mem_sel),    32'd0);
      check("post-reset core_rst", 32'(core_reset), 32'd1);
    end

    // ---- Short empty download after reset: release timing ----
    dn_download = 1'b1;
    tick();
    dn_download = 1'b0;
    done_at = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (dl_done === 1'b1 && done_at == 0) done_at = i;
    end
    check("second release cycle", 32'(done_at), 32'd6);
    check("second release level", 32'(core_reset), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
